// File: rtl/multdiv_ctrl_pkg.sv
// Shared encodings, latencies and helpers for the mult/div issue controller
// and the iterative multdiv unit it sequences.
package multdiv_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_WAIT  = ST_WAIT,
        S_WB    = ST_WB
    } ctrl_state_e;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned MULT_LAT        = 17;
    localparam int unsigned DIV_LAT         = 33;
    localparam int unsigned TIMEOUT_DEFAULT = 40;

    // Operation held stable towards multdiv for the whole run
    typedef struct packed {
        logic              is_div;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
    } md_op_t;

    // Two's-complement magnitude; -2^31 maps to 0x8000_0000 unsigned
    function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
    endfunction

endpackage

// File: rtl/multdiv.sv
// Iterative signed multiply (2 bits/cycle) and restoring divide (1 bit/cycle).
// A ctrl pulse restarts the unit; resultRDY stays high until the next pulse.
module multdiv
    import multdiv_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    logic        run_q, div_q, neg_q, dz_q, rdy_q, exc_q;
    logic [5:0]  step_q;
    logic [63:0] mcand_q, acc_q;
    logic [31:0] mplier_q, rem_q, quo_q, dvsr_q, result_q;

    logic [63:0] acc_n;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_n, quo_n, res_n;
    logic        exc_n, last;

    always_comb begin
        acc_n  = acc_q
               + (mplier_q[0] ? mcand_q : 64'd0)
               + (mplier_q[1] ? {mcand_q[62:0], 1'b0} : 64'd0);
        rem_sh = {rem_q, quo_q[31]};
        fits   = (rem_sh >= {1'b0, dvsr_q});
        rem_n  = fits ? 32'(rem_sh - {1'b0, dvsr_q}) : rem_sh[31:0];
        quo_n  = {quo_q[30:0], fits};
        last   = (step_q == (div_q ? 6'(DIV_LAT - 2) : 6'(MULT_LAT - 2)));
        res_n  = '0;
        exc_n  = 1'b0;
        if (div_q) begin
            res_n = dz_q ? 32'd0 : (neg_q ? (~quo_n + 32'd1) : quo_n);
            exc_n = dz_q | (~neg_q & quo_n[31]);
        end else begin
            res_n = neg_q ? (~acc_n[31:0] + 32'd1) : acc_n[31:0];
            exc_n = neg_q ? (acc_n > 64'h0000_0000_8000_0000)
                          : (acc_n > 64'h0000_0000_7FFF_FFFF);
        end
    end

    // Unit has no async clear: every ctrl pulse reloads all working state
    always_ff @(posedge clock) begin
        if (reset) begin
            run_q <= 1'b0;
            rdy_q <= 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            run_q    <= 1'b1;
            rdy_q    <= 1'b0;
            div_q    <= ctrl_DIV;
            step_q   <= '0;
            neg_q    <= data_operandA[31] ^ data_operandB[31];
            dz_q     <= (data_operandB == 32'd0);
            mcand_q  <= {32'd0, mag32(data_operandA)};
            mplier_q <= mag32(data_operandB);
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= mag32(data_operandA);
            dvsr_q   <= mag32(data_operandB);
        end else if (run_q) begin
            step_q   <= step_q + 6'd1;
            acc_q    <= acc_n;
            mcand_q  <= {mcand_q[61:0], 2'b00};
            mplier_q <= {2'b00, mplier_q[31:2]};
            rem_q    <= rem_n;
            quo_q    <= quo_n;
            if (last) begin
                run_q    <= 1'b0;
                rdy_q    <= 1'b1;
                result_q <= res_n;
                exc_q    <= exc_n;
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Sequences one mult/div op at a time through multdiv: start pulse, timeout,
// regfile writeback handshake and RAW stall against the pending destination.
module multdiv_issue_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned RW      = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic          issue_is_div,
    input  logic [31:0]   issue_opA,
    input  logic [31:0]   issue_opB,
    input  logic [RW-1:0] issue_rd,
    output logic          issue_ready,
    input  logic [RW-1:0] dec_rs,
    input  logic [RW-1:0] dec_rt,
    output logic          stall,
    output logic          busy,
    output logic          wb_valid,
    output logic [RW-1:0] wb_rd,
    output logic [31:0]   wb_data,
    output logic          wb_exception,
    input  logic          wb_ready
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    ctrl_state_e   state_q, state_d;
    md_op_t        op_q, op_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          wb_exc_q, wb_exc_d;

    logic          md_mult, md_div, md_rdy, md_exc;
    logic [31:0]   md_result;
    logic          hazard;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q      <= '0;
            rd_q      <= '0;
            tmo_q     <= '0;
            wb_data_q <= '0;
            wb_exc_q  <= 1'b0;
        end else begin
            op_q      <= op_d;
            rd_q      <= rd_d;
            tmo_q     <= tmo_d;
            wb_data_q <= wb_data_d;
            wb_exc_q  <= wb_exc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        tmo_d     = tmo_q;
        wb_data_d = wb_data_q;
        wb_exc_d  = wb_exc_q;
        case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    op_d    = '{is_div: issue_is_div, op_a: issue_opA, op_b: issue_opB};
                    rd_d    = issue_rd;
                    tmo_d   = '0;
                    state_d = S_START;
                end
            end
            // resultRDY is stale here, so it is deliberately not looked at
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (md_rdy) begin
                    wb_data_d = md_result;
                    wb_exc_d  = md_exc;
                    state_d   = (rd_q == '0) ? S_IDLE : S_WB;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    wb_data_d = '0;
                    wb_exc_d  = 1'b1;
                    state_d   = (rd_q == '0) ? S_IDLE : S_WB;
                end
            end
            S_WB: begin
                if (wb_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign md_mult = (state_q == S_START) & ~op_q.is_div;
    assign md_div  = (state_q == S_START) &  op_q.is_div;

    multdiv u_multdiv (
        .clock          (clock),
        .reset          (1'b0),
        .ctrl_MULT      (md_mult),
        .ctrl_DIV       (md_div),
        .data_operandA  (op_q.op_a),
        .data_operandB  (op_q.op_b),
        .data_result    (md_result),
        .data_exception (md_exc),
        .data_resultRDY (md_rdy)
    );

    assign issue_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign hazard       = busy & (rd_q != '0) & ((dec_rs == rd_q) | (dec_rt == rd_q));
    assign stall        = (issue_valid & ~issue_ready) | hazard;
    assign wb_valid     = (state_q == S_WB);
    assign wb_rd        = rd_q;
    assign wb_data      = wb_data_q;
    assign wb_exception = wb_exc_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Randomized bench for multdiv_issue_ctrl: directed ops first, then random ops,
// checked every cycle against a latency/handshake reference model.
module tb_multdiv_issue_ctrl;

    localparam int unsigned RW     = 5;
    localparam int          NCYC   = 4000;
    localparam longint      MAXV   = 64'sd2147483647;
    localparam longint      MINV   = -64'sd2147483648;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_is_div = 1'b0;
    logic [31:0]   issue_opA = '0;
    logic [31:0]   issue_opB = '0;
    logic [RW-1:0] issue_rd = '0;
    logic          issue_ready;
    logic [RW-1:0] dec_rs = '0;
    logic [RW-1:0] dec_rt = '0;
    logic          stall, busy, wb_valid, wb_exception;
    logic [RW-1:0] wb_rd;
    logic [31:0]   wb_data;
    logic          wb_ready = 1'b0;

    always #5 clock = ~clock;

    multdiv_issue_ctrl #(.TIMEOUT(40), .RW(RW)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_is_div (issue_is_div),
        .issue_opA    (issue_opA),
        .issue_opB    (issue_opB),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .dec_rs       (dec_rs),
        .dec_rt       (dec_rt),
        .stall        (stall),
        .busy         (busy),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_exception (wb_exception),
        .wb_ready     (wb_ready)
    );

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          rst_at;
    } op_t;

    int  checks = 0;
    int  failures = 0;
    int  ops_done = 0;
    op_t dir_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_issue_ready"}, 64'(issue_ready), 64'd1);
        check_eq({pfx, "_stall"}, 64'(stall), 64'd0);
        check_eq({pfx, "_busy"}, 64'(busy), 64'd0);
        check_eq({pfx, "_wb_valid"}, 64'(wb_valid), 64'd0);
        check_eq({pfx, "_wb_rd"}, 64'(wb_rd), 64'd0);
        check_eq({pfx, "_wb_data"}, 64'(wb_data), 64'd0);
        check_eq({pfx, "_wb_exception"}, 64'(wb_exception), 64'd0);
    endtask

    function automatic op_t mk_op(bit d, logic [31:0] a, logic [31:0] b, logic [4:0] rd, int rst_at);
        op_t o;
        o.is_div = d; o.a = a; o.b = b; o.rd = rd; o.rst_at = rst_at;
        return o;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom % 7)
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom % 2000) - 32'd1000;
            default: return 32'($urandom);
        endcase
    endfunction

    // Model: phase 0 idle, 1 running (START/WAIT), 2 writeback
    int          m_phase = 0;
    int          m_left = 0;
    int          m_since = 0;
    int          m_rst_at = 0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    bit          m_exc = 1'b0;
    bit          pend = 1'b0;
    op_t         pop;

    task automatic model_accept(input op_t o);
        longint sa, sb, r;
        sa = longint'($signed(o.a));
        sb = longint'($signed(o.b));
        if (!o.is_div) begin
            r      = sa * sb;
            m_data = 32'(r);
            m_exc  = (r > MAXV) || (r < MINV);
        end else if (o.b == 32'd0) begin
            m_data = 32'd0;
            m_exc  = 1'b1;
        end else begin
            r      = sa / sb;
            m_data = 32'(r);
            m_exc  = (r > MAXV) || (r < MINV);
        end
        m_phase  = 1;
        m_left   = o.is_div ? 34 : 18;
        m_since  = 0;
        m_rd     = o.rd;
        m_rst_at = o.rst_at;
    endtask

    initial begin
        bit stall_e;
        dir_q.push_back(mk_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0));
        dir_q.push_back(mk_op(1'b1, 32'd100, 32'd7, 5'd9, 0));
        dir_q.push_back(mk_op(1'b1, 32'd5, 32'd0, 5'd3, 0));
        dir_q.push_back(mk_op(1'b0, 32'h4000_0000, 32'd4, 5'd4, 0));
        dir_q.push_back(mk_op(1'b0, 32'h8000_0000, 32'h8000_0000, 5'd6, 0));
        dir_q.push_back(mk_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0));
        dir_q.push_back(mk_op(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd8, 0));
        dir_q.push_back(mk_op(1'b0, 32'd12, 32'd34, 5'd0, 0));
        dir_q.push_back(mk_op(1'b1, 32'd1000, 32'd3, 5'd10, 10));
        dir_q.push_back(mk_op(1'b0, 32'd6, 32'd6, 5'd11, 0));

        #12;
        check_reset_outputs("por");
        @(negedge clock);
        reset = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clock);
            #2;
            if (m_phase == 1 && m_rst_at != 0 && m_since == m_rst_at) begin
                issue_valid = 1'b0;
                reset = 1'b0;
                #1;
                check_reset_outputs("midop_reset");
                m_phase = 0;
                reset = 1'b1;
                #1;
            end
            if (!pend && ($urandom % 4 != 0)) begin
                pend = 1'b1;
                if (dir_q.size() > 0) pop = dir_q.pop_front();
                else pop = mk_op(1'($urandom), rand_operand(), rand_operand(), 5'($urandom), 0);
            end
            issue_valid  = pend;
            issue_is_div = pop.is_div;
            issue_opA    = pop.a;
            issue_opB    = pop.b;
            issue_rd     = pop.rd;
            dec_rs       = (m_phase != 0 && $urandom % 3 == 0) ? m_rd : RW'($urandom);
            dec_rt       = (m_phase != 0 && $urandom % 3 == 0) ? m_rd : RW'($urandom);
            wb_ready     = ($urandom % 3 != 0);
            #1;

            stall_e = (issue_valid && m_phase != 0) ||
                      (m_phase != 0 && m_rd != 0 && (dec_rs == m_rd || dec_rt == m_rd));
            check_eq("issue_ready", 64'(issue_ready), 64'(m_phase == 0));
            check_eq("busy", 64'(busy), 64'(m_phase != 0));
            check_eq("stall", 64'(stall), 64'(stall_e));
            check_eq("wb_valid", 64'(wb_valid), 64'(m_phase == 2));
            if (m_phase == 2) begin
                check_eq("wb_rd", 64'(wb_rd), 64'(m_rd));
                check_eq("wb_data", 64'(wb_data), 64'(m_data));
                check_eq("wb_exception", 64'(wb_exception), 64'(m_exc));
            end

            if (m_phase == 0) begin
                if (issue_valid) begin
                    model_accept(pop);
                    pend = 1'b0;
                end
            end else if (m_phase == 1) begin
                m_since++;
                m_left--;
                if (m_left == 0) begin
                    m_phase = (m_rd == 0) ? 0 : 2;
                    ops_done++;
                end
            end else if (wb_ready) begin
                m_phase = 0;
            end
        end

        check_eq("ops_completed_min", 64'(ops_done >= 20), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multdiv_issue_ctrl.md
# multdiv_issue_ctrl

Sequencing controller that connects the pipeline's execute stage to the shared `multdiv` unit. It accepts one multiply or divide at a time and holds the operands stable for the whole operation. It generates the single-cycle start pulse, blanks the stale ready flag, and enforces a timeout. It then hands the result to the register-file writeback port with a valid/ready handshake, and stalls decode on read-after-write hazards against the pending destination register.

## Interface
Parameters:
- `TIMEOUT`, 40 — maximum WAIT cycles before forced completion; must exceed 33.
- `RW`, 5 — register-address width.

Ports:
- `clock`  in  1  — the block's only clock.
- `reset`  in  1  — asynchronous, active-low.
- `issue_valid`  in  1  — execute stage presents a mult/div op.
- `issue_is_div`  in  1  — 1 = divide, 0 = multiply.
- `issue_opA`, `issue_opB`  in  32 each  — operands (A = multiplicand or dividend).
- `issue_rd`  in  RW  — destination register.
- `issue_ready`  out  1  — op accepted on any edge where valid & ready.
- `dec_rs`, `dec_rt`  in  RW each  — decode-stage source registers.
- `stall`  out  1  — freeze fetch, decode and execute.
- `busy`  out  1  — state ≠ IDLE.
- `wb_valid`  out  1  — writeback request.
- `wb_rd`  out  RW  — writeback destination.
- `wb_data`  out  32  — writeback value.
- `wb_exception`  out  1  — overflow, divide-by-zero or timeout.
- `wb_ready`  in  1  — regfile port granted.

## Operation
States: IDLE, START, WAIT, WB.
- **IDLE**
  - `issue_ready` = 1.
  - On valid & ready: latch opA, opB, rd and is_div into hold registers, clear the timeout counter, go to START.
- **START** (exactly 1 cycle)
  - Drive `ctrl_MULT` or `ctrl_DIV` = 1 to `multdiv` per the latched is_div.
  - Ignore `data_resultRDY`; it still reflects the previous op until the edge that ends this cycle.
  - Go to WAIT.
- **WAIT**
  - Both ctrl lines = 0.
  - `multdiv` operands are driven only from the hold registers.
  - Timeout counter increments each cycle.
  - If `data_resultRDY` = 1: capture `data_result` into `wb_data` and `data_exception` into `wb_exception`. Go to WB, or to IDLE if the latched rd = 0.
  - Else, if the counter = TIMEOUT−1: `wb_data` ← 0, `wb_exception` ← 1. Go to WB, or to IDLE if rd = 0.
- **WB**
  - `wb_valid` = 1, `wb_rd` = latched rd.
  - `wb_data` and `wb_exception` are held stable until the handshake.
  - Go to IDLE on the edge where `wb_ready` = 1.
  - No new issue is accepted in WB.

Hazard and stall rules:
- `hazard` = busy & (rd ≠ 0) & ((`dec_rs` = rd) | (`dec_rt` = rd)).
- `stall` = (`issue_valid` & ~`issue_ready`) | `hazard`.
- `stall` is combinational from state and inputs.

Boundary conditions:
- rd = 0: the operation runs to completion, but `wb_valid` is never raised.
- `issue_valid` during START, WAIT or WB: the op is not accepted and `stall` = 1. The op must be held by the pipeline.
- RDY and timeout in the same cycle: RDY wins, and `wb_exception` = `data_exception`.
- Reset mid-operation: immediate return to IDLE and every output to its reset value. `multdiv`'s internal counters need no reset, because the next START pulse restarts them.
- Overflow, divide-by-zero, −2³¹ × −2³¹ and a zero operand are all resolved inside `multdiv`. The controller only forwards the exception flag.

## Timing
- Reset values: state IDLE, `issue_ready` = 1, `stall` = 0, `busy` = 0, `wb_valid` = 0, `wb_rd` = 0, `wb_data` = 0, `wb_exception` = 0, ctrl pulses = 0.
- Call the accept edge E0.
  - START is the cycle after E0.
  - Multiply: RDY is visible after E17; `wb_valid` is first high after E18.
  - Divide: RDY after E33; `wb_valid` after E34.
- `wb_valid` stays high until the `wb_ready` edge. The next issue can be accepted on the edge after the return to IDLE.
- `stall` rises in the same cycle as a conflicting decode, with no latency.

## Structure
- Package `multdiv_ctrl_pkg`:
  - state encoding localparams (IDLE = 0, START = 1, WAIT = 2, WB = 3);
  - `MULT_LAT` = 17 and `DIV_LAT` = 33;
  - default `TIMEOUT`.
- One sub-module: the existing `multdiv`, instantiated internally.
  - Its `reset` port is tied to 0.
  - Its operand inputs are fed only from the hold registers.
- Hold, timeout and writeback registers all use the async active-low clear.

## Test plan
1. Issue mult 7 × −3 (0xFFFFFFFD), rd = 5, `wb_ready` tied 1 → `wb_valid` after E18, `wb_data` = 0xFFFFFFEB, `wb_exception` = 0, `wb_rd` = 5.
2. Issue div 100 / 7, rd = 9 → `wb_valid` after E34, `wb_data` = 14, `wb_exception` = 0.
3. Div 5 / 0, rd = 3 → `wb_exception` = 1. The mult 0x40000000 × 4 → `wb_exception` = 1.
4. During a busy op with rd = 5, drive `dec_rs` = 5 → `stall` = 1. Drive `dec_rt` = 6 → `stall` = 0. Hold `issue_valid` on a second op → `stall` = 1 and the second op is issued only after IDLE.
5. Hold `wb_ready` = 0 for 3 cycles → `wb_valid`, `wb_data` and `wb_rd` are stable; IDLE follows the `wb_ready` edge. Issue with rd = 0 → `wb_valid` never rises and `busy` drops after RDY.
6. Assert `reset` low in cycle 10 of a divide → all outputs return to reset values asynchronously. A following mult 6 × 6 → `wb_data` = 36 after E18.
